// File: rtl/sdsu_bus_pkg.sv
// rtl/sdsu_bus_pkg.sv - shared bus width defaults and arbiter state encoding
package sdsu_bus_pkg;
    localparam int ADR_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/sdsu_bus_arbiter_if.sv
// rtl/sdsu_bus_arbiter_if.sv - master-side and slave-side sdsu_bus signals around the arbiter
interface sdsu_bus_arbiter_if
    import sdsu_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = ADR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_signal;
    logic [NUM_MASTERS*ADR_W-1:0]  m_w_adr;
    logic [NUM_MASTERS*ADR_W-1:0]  m_r_adr;
    logic [NUM_MASTERS*DATA_W-1:0] m_w_data;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_ready;
    logic [DATA_W-1:0]             m_r_data;
    logic                          sl_signal;
    logic [ADR_W-1:0]              sl_w_adr;
    logic [ADR_W-1:0]              sl_r_adr;
    logic [DATA_W-1:0]             sl_w_data;
    logic [DATA_W-1:0]             sl_r_data;
    logic                          sl_ready;

    // Arbiter view
    modport slave (
        input  m_req, m_signal, m_w_adr, m_r_adr, m_w_data, sl_r_data, sl_ready,
        output m_gnt, m_ready, m_r_data, sl_signal, sl_w_adr, sl_r_adr, sl_w_data
    );

    // Environment view: the requesters plus the register-file slave
    modport master (
        output m_req, m_signal, m_w_adr, m_r_adr, m_w_data, sl_r_data, sl_ready,
        input  m_gnt, m_ready, m_r_data, sl_signal, sl_w_adr, sl_r_adr, sl_w_data
    );
endinterface

// File: rtl/sdsu_bus_arbiter_rr_pick.sv
// rtl/sdsu_bus_arbiter_rr_pick.sv - combinational round-robin picker searching upward from ptr+1
module sdsu_bus_arbiter_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // The last master examined is ptr itself, so the previous winner ranks lowest.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
                gnt[(int'(ptr) + i) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdsu_bus_arbiter.sv
// rtl/sdsu_bus_arbiter.sv - round-robin owner arbitration of the single sdsu_bus slave port
module sdsu_bus_arbiter
    import sdsu_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADR_W       = ADR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_HOLD    = 16
) (
    input logic               clk,
    input logic               rst_n,
    sdsu_bus_arbiter_if.slave bus
);
    localparam int IW    = $clog2(NUM_MASTERS);
    localparam int HC_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int LIMIT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t             state;
    logic [NUM_MASTERS-1:0] gnt;
    logic [IW-1:0]          rr_ptr;
    logic [HC_W-1:0]        hold_cnt;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   timeout;
    logic [ADR_W-1:0]       mux_w_adr, mux_r_adr, held_w_adr, held_r_adr;
    logic [DATA_W-1:0]      mux_w_data, held_w_data;

    sdsu_bus_arbiter_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req (bus.m_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign timeout = (MAX_HOLD != 0) && (hold_cnt == HC_W'(LIMIT));

    // rr_ptr doubles as the owner index once a grant has been issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= IW'(NUM_MASTERS - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt      <= pick_gnt;
                        rr_ptr   <= pick_idx;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: state <= ST_OWN;
                ST_OWN: begin
                    if (!bus.m_req[rr_ptr] || timeout) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mux_w_adr  = bus.m_w_adr[rr_ptr*ADR_W +: ADR_W];
        mux_r_adr  = bus.m_r_adr[rr_ptr*ADR_W +: ADR_W];
        mux_w_data = bus.m_w_data[rr_ptr*DATA_W +: DATA_W];
    end

    // Snapshot of the owner's fields so the slave sees stable values while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_w_adr  <= '0;
            held_r_adr  <= '0;
            held_w_data <= '0;
        end else if (state != ST_IDLE) begin
            held_w_adr  <= mux_w_adr;
            held_r_adr  <= mux_r_adr;
            held_w_data <= mux_w_data;
        end
    end

    assign bus.sl_w_adr  = (state == ST_IDLE) ? held_w_adr  : mux_w_adr;
    assign bus.sl_r_adr  = (state == ST_IDLE) ? held_r_adr  : mux_r_adr;
    assign bus.sl_w_data = (state == ST_IDLE) ? held_w_data : mux_w_data;
    assign bus.sl_signal = (state == ST_OWN) && bus.m_signal[rr_ptr];
    assign bus.m_gnt     = gnt;
    assign bus.m_r_data  = bus.sl_r_data;

    always_comb begin
        bus.m_ready = '0;
        if (state == ST_OWN) begin
            bus.m_ready[rr_ptr] = bus.sl_ready;
        end
    end
endmodule

// File: tb/tb_sdsu_bus_arbiter.sv
// tb/tb_sdsu_bus_arbiter.sv - scoreboard bench for the sdsu_bus round-robin arbiter
module tb_sdsu_bus_arbiter;
    localparam int NM = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdsu_bus_arbiter_if #(.NUM_MASTERS(NM), .ADR_W(AW), .DATA_W(DW)) bus ();

    sdsu_bus_arbiter #(.NUM_MASTERS(NM), .ADR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    task automatic set_master(input int m, input logic sig, input logic [AW-1:0] wa,
                              input logic [AW-1:0] ra, input logic [DW-1:0] wd);
        bus.m_signal[m]          = sig;
        bus.m_w_adr[m*AW +: AW]  = wa;
        bus.m_r_adr[m*AW +: AW]  = ra;
        bus.m_w_data[m*DW +: DW] = wd;
    endtask

    task automatic clear_inputs();
        bus.m_req     = '0;
        bus.m_signal  = '0;
        bus.m_w_adr   = '0;
        bus.m_r_adr   = '0;
        bus.m_w_data  = '0;
        bus.sl_r_data = '0;
        bus.sl_ready  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for any grant; returns the vector seen at that negedge.
    task automatic wait_gnt(output logic [NM-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.m_gnt != '0) begin
                ok = 1'b1;
                g  = bus.m_gnt;
                break;
            end
        end
    endtask

    task automatic drain();
        bit gone;
        gone = 1'b0;
        bus.m_req = '0;
        for (int c = 0; c < 40 && !gone; c++) begin
            @(negedge clk);
            if (bus.m_gnt == '0) gone = 1'b1;
        end
        n_cmp++;
        if (!gone) begin
            n_bad++;
            $display("FAIL drain: m_gnt=%b still set, expected 0000", bus.m_gnt);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [NM-1:0] g, eg;
        bit ok;
        int e;
        clear_inputs();
        rst_n = 1'b0;
        bus.m_req = 4'b1111;
        bus.m_signal = 4'b1111;
        bus.sl_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.m_gnt !== 4'b0000 || bus.m_ready !== 4'b0000 || bus.sl_signal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: gnt=%b ready=%b sl_signal=%b, expected 0000 0000 0", bus.m_gnt, bus.m_ready, bus.sl_signal);
        end
        n_cmp++;
        if (bus.sl_w_adr !== '0 || bus.sl_r_adr !== '0 || bus.sl_w_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: w_adr=%h r_adr=%h w_data=%h, expected 0", bus.sl_w_adr, bus.sl_r_adr, bus.sl_w_data);
        end
        bus.sl_ready = 1'b0;
        bus.m_signal = '0;
        rst_n = 1'b1;
        exp_q.push_back(0);
        @(negedge clk);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (bus.m_gnt !== eg) begin
            n_bad++;
            $display("FAIL reset_first_gnt: m_gnt=%b expected %b", bus.m_gnt, eg);
        end
        drain();
        g = '0;
        ok = 1'b0;
    endtask

    task automatic test_single_write();
        logic [NM-1:0] g, eg;
        bit ok;
        int e;
        set_master(2, 1'b1, 5'd1, 5'd3, 32'd7);
        bus.m_req = 4'b0100;
        exp_q.push_back(2);
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL write_gnt: m_gnt=%b expected %b", g, eg);
        end
        n_cmp++;
        if (bus.sl_signal !== 1'b0 || bus.sl_w_adr !== 5'd1) begin
            n_bad++;
            $display("FAIL write_grant_settle: sl_signal=%b w_adr=%0d, expected 0 1", bus.sl_signal, bus.sl_w_adr);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.sl_signal !== 1'b1 || bus.sl_w_adr !== 5'd1 || bus.sl_w_data !== 32'd7 || bus.sl_r_adr !== 5'd3) begin
            n_bad++;
            $display("FAIL write_own: sig=%b w_adr=%0d w_data=%0d r_adr=%0d, expected 1 1 7 3",
                     bus.sl_signal, bus.sl_w_adr, bus.sl_w_data, bus.sl_r_adr);
        end
        bus.sl_ready = 1'b1;
        bus.sl_r_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (bus.m_ready !== 4'b0100 || bus.m_r_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL write_ready: m_ready=%b r_data=%h, expected 0100 deadbeef", bus.m_ready, bus.m_r_data);
        end
        bus.sl_ready = 1'b0;
        set_master(2, 1'b0, 5'd0, 5'd0, 32'd0);
        drain();
    endtask

    task automatic test_fairness();
        logic [NM-1:0] g, eg;
        bit ok;
        int e;
        pulse_reset();
        bus.m_req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, ok);
            e = exp_q.pop_front();
            eg = '0;
            eg[e] = 1'b1;
            n_cmp++;
            if (!ok || g !== eg) begin
                n_bad++;
                $display("FAIL fair_gnt%0d: m_gnt=%b expected %b", k, g, eg);
            end
            repeat (3) @(negedge clk);
            bus.m_req[e] = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.m_gnt !== 4'b0000) begin
                n_bad++;
                $display("FAIL fair_dead%0d: m_gnt=%b expected 0000", k, bus.m_gnt);
            end
            bus.m_req[e] = 1'b1;
        end
        drain();
    endtask

    task automatic test_timeout();
        logic [NM-1:0] g, eg;
        bit ok;
        int e, own_cycles;
        pulse_reset();
        set_master(1, 1'b1, 5'd2, 5'd2, 32'h11);
        bus.m_req = 4'b1010;
        exp_q.push_back(1);
        exp_q.push_back(3);
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL tmo_first_gnt: m_gnt=%b expected %b", g, eg);
        end
        own_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.sl_signal === 1'b1) own_cycles++;
            if (bus.m_gnt == '0) break;
        end
        n_cmp++;
        if (own_cycles != MH) begin
            n_bad++;
            $display("FAIL tmo_hold: own cycles=%0d expected %0d", own_cycles, MH);
        end
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL tmo_next_gnt: m_gnt=%b expected %b", g, eg);
        end
        set_master(1, 1'b0, 5'd0, 5'd0, 32'd0);
        drain();
    endtask

    task automatic test_isolation();
        logic [NM-1:0] g, eg;
        bit ok;
        int e;
        pulse_reset();
        set_master(1, 1'b0, 5'd5, 5'd6, 32'h55);
        set_master(0, 1'b1, 5'd16, 5'd16, 32'hFFFF);
        bus.m_req = 4'b0010;
        exp_q.push_back(1);
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL iso_gnt: m_gnt=%b expected %b", g, eg);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.sl_signal !== 1'b0 || bus.sl_w_adr !== 5'd5) begin
            n_bad++;
            $display("FAIL iso_own: sl_signal=%b w_adr=%0d, expected 0 5", bus.sl_signal, bus.sl_w_adr);
        end
        bus.sl_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.m_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL iso_ready: m_ready=%b expected 0010", bus.m_ready);
        end
        bus.sl_ready = 1'b0;
        bus.m_req = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.m_gnt !== 4'b0000 || bus.sl_signal !== 1'b0 || bus.sl_w_adr !== 5'd5) begin
            n_bad++;
            $display("FAIL iso_idle_hold: gnt=%b sig=%b w_adr=%0d, expected 0000 0 5", bus.m_gnt, bus.sl_signal, bus.sl_w_adr);
        end
        clear_inputs();
        drain();
    endtask

    task automatic test_midop_reset();
        logic [NM-1:0] g, eg;
        bit ok;
        int e;
        pulse_reset();
        set_master(2, 1'b1, 5'd9, 5'd9, 32'h99);
        bus.m_req = 4'b0100;
        exp_q.push_back(2);
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL midrst_gnt: m_gnt=%b expected %b", g, eg);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.sl_signal !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_own: sl_signal=%b expected 1", bus.sl_signal);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.sl_signal !== 1'b0 || bus.m_gnt !== 4'b0000 || bus.sl_w_adr !== 5'd0) begin
            n_bad++;
            $display("FAIL midrst_drop: sig=%b gnt=%b w_adr=%0d, expected 0 0000 0", bus.sl_signal, bus.m_gnt, bus.sl_w_adr);
        end
        bus.m_signal = '0;
        bus.m_req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(0);
        wait_gnt(g, ok);
        e = exp_q.pop_front();
        eg = '0;
        eg[e] = 1'b1;
        n_cmp++;
        if (!ok || g !== eg) begin
            n_bad++;
            $display("FAIL midrst_regnt: m_gnt=%b expected %b", g, eg);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_timeout();
        test_isolation();
        test_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
